// File: rtl/pong_pkg.sv
// Shared types and constants for the PONG serial keyboard front end.
// Holds the UART receiver state encoding, default bit timing and paddle key codes.
package pong_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      CLEANUP
   } uart_rx_state_t;

   // 25 MHz system clock at 115200 baud
   localparam int CLKS_PER_BIT_DEFAULT = 217;

   localparam logic [7:0] KEY_UP_L = 8'd119;
   localparam logic [7:0] KEY_DN_L = 8'd115;
   localparam logic [7:0] KEY_UP_R = 8'd111;
   localparam logic [7:0] KEY_DN_R = 8'd108;

endpackage

// File: rtl/rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops reset to RESET_VALUE so an idle-high line reads idle straight out of reset.
module rx_sync_2ff #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VALUE;
         q    <= RESET_VALUE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_key_rx.sv
// 8N1 UART receiver driving the paddle key bus; framing errors never reach o_key_byte.
// Build option UART_RX_HOLD_EN: when defined o_key_byte holds the last good byte, otherwise it is 0x00 outside o_rx_dv.
module uart_key_rx
   import pong_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       i_CLK,
   input  logic       i_RST,
   input  logic       i_RX,
   output logic [7:0] o_key_byte,
   output logic       o_rx_dv,
   output logic       o_frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

   uart_rx_state_t state;
   uart_rx_state_t state_next;

   logic          rx_s;
   logic          armed;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;
   logic          tick_half;
   logic          tick_full;
   logic          dv_next;
   logic          err_next;
   logic [7:0]    key_next;

   rx_sync_2ff #(
      .RESET_VALUE(1'b1)
   ) u_sync (
      .clk (i_CLK),
      .rst (i_RST),
      .d   (i_RX),
      .q   (rx_s)
   );

   assign tick_half = (bit_cnt == HALF_BIT);
   assign tick_full = (bit_cnt == LAST_TICK);

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (armed && !rx_s) state_next = START;
         START:   if (tick_half) state_next = rx_s ? IDLE : DATA;
         DATA:    if (tick_full && (bit_idx == 3'd7)) state_next = STOP;
         STOP:    if (tick_full) state_next = CLEANUP;
         CLEANUP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      dv_next  = 1'b0;
      err_next = 1'b0;
      if ((state == STOP) && tick_full) begin
         dv_next  = rx_s;
         err_next = !rx_s;
      end
`ifdef UART_RX_HOLD_EN
      key_next = dv_next ? shift_reg : o_key_byte;
`else
      key_next = dv_next ? shift_reg : 8'h00;
`endif
   end

   // Armed only after the line has been seen high, so a reset inside a frame cannot mistake a low data bit for a start bit
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         armed       <= 1'b0;
         bit_cnt     <= '0;
         bit_idx     <= '0;
         shift_reg   <= '0;
         o_key_byte  <= '0;
         o_rx_dv     <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         o_rx_dv     <= dv_next;
         o_frame_err <= err_next;
         o_key_byte  <= key_next;
         if (rx_s) begin
            armed <= 1'b1;
         end
         case (state)
            START: begin
               if (tick_half) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            DATA: begin
               if (tick_full) begin
                  bit_cnt            <= '0;
                  shift_reg[bit_idx] <= rx_s;
                  if (bit_idx != 3'd7) begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            STOP: begin
               if (tick_full) begin
                  bit_cnt <= '0;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: bit_cnt <= '0;
         endcase
      end
   end

endmodule
